// File: rtl/mux_demux_scan_if.sv
// Channel-select bus for mux_demux_scan: control strobes, mux/demux data and status.
// The master drives the control and data inputs; the slave (the block) returns the registered outputs.
interface mux_demux_scan_if #(
  parameter int CH = 4,
  parameter int W  = 1
);
  localparam int SELW = $clog2(CH);

  logic            en;
  logic            mode;
  logic            sel_load;
  logic [SELW-1:0] sel_in;
  logic [CH*W-1:0] I;
  logic [W-1:0]    Y;
  logic [W-1:0]    D;
  logic [CH*W-1:0] Yd;
  logic [SELW-1:0] sel_cur;
  logic            wrap;
  logic            sel_err;

  modport master (
    output en, mode, sel_load, sel_in, I, D,
    input  Y, Yd, sel_cur, wrap, sel_err
  );

  modport slave (
    input  en, mode, sel_load, sel_in, I, D,
    output Y, Yd, sel_cur, wrap, sel_err
  );
endinterface

// File: rtl/mux_demux_scan.sv
// Registered CH-channel mux/demux sharing one selector, loaded manually or advanced by a dwell scan.
// Optional macro BREAK_BEFORE_MAKE_EN blanks Y/Yd for one cycle whenever the selector changes.
module mux_demux_scan #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int DWELL = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux_demux_scan_if.slave bus
);
  localparam int SELW = $clog2(CH);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] SEL_LAST = SELW'(CH - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [SELW-1:0] sel_p1, sel_next;
  logic [CNTW-1:0] cnt_p1, cnt_next;
  logic            wrap_p1, wrap_next;
  logic            err_p1, err_next;
  logic [W-1:0]    y_p1, y_next;
  logic [CH*W-1:0] yd_p1, yd_next;
  logic            in_range;
  logic            load_ok;

  // Every encodable selector is a real channel when CH is a power of two.
  generate
    if ((1 << SELW) == CH) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = (bus.sel_in <= SEL_LAST);
    end
  endgenerate

  assign load_ok = bus.sel_load && in_range;

  // Stage 0: next selector, dwell count and status pulses
  always_comb begin
    sel_next  = sel_p1;
    cnt_next  = cnt_p1;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (bus.en) begin
      err_next = bus.sel_load && !in_range;
      if (load_ok) begin
        sel_next = bus.sel_in;
        cnt_next = '0;
      end else if (bus.mode) begin
        if (cnt_p1 == CNT_LAST) begin
          cnt_next  = '0;
          wrap_next = (sel_p1 == SEL_LAST);
          sel_next  = (sel_p1 == SEL_LAST) ? '0 : sel_p1 + SELW'(1);
        end else begin
          cnt_next = cnt_p1 + CNTW'(1);
        end
      end else begin
        cnt_next = '0;
      end
    end
  end

  // Data is routed by the selector being registered this cycle, not the old one.
  always_comb begin
    y_next  = '0;
    yd_next = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel_next == SELW'(k)) begin
        y_next            = bus.I[k*W +: W];
        yd_next[k*W +: W] = bus.D;
      end
    end
`ifdef BREAK_BEFORE_MAKE_EN
    if (sel_next != sel_p1) begin
      y_next  = '0;
      yd_next = '0;
    end
`endif
  end

  // Stage 1: registered selector, status and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_p1  <= '0;
      cnt_p1  <= '0;
      wrap_p1 <= 1'b0;
      err_p1  <= 1'b0;
      y_p1    <= '0;
      yd_p1   <= '0;
    end else begin
      sel_p1  <= sel_next;
      cnt_p1  <= cnt_next;
      wrap_p1 <= wrap_next;
      err_p1  <= err_next;
      if (bus.en) begin
        y_p1  <= y_next;
        yd_p1 <= yd_next;
      end
    end
  end

  assign bus.Y       = y_p1;
  assign bus.Yd      = yd_p1;
  assign bus.sel_cur = sel_p1;
  assign bus.wrap    = wrap_p1;
  assign bus.sel_err = err_p1;
endmodule

// File: tb/tb_mux_demux_scan.sv
// Self-checking bench for mux_demux_scan: directed scenarios plus randomized traffic on a
// CH=4/W=1/DWELL=8 instance and a CH=3/W=2/DWELL=3 instance, both against a behavioural model.
module tb_mux_demux_scan;
`ifdef BREAK_BEFORE_MAKE_EN
  localparam bit BBM = 1'b1;
`else
  localparam bit BBM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_demux_scan_if #(.CH(4), .W(1)) b4();
  mux_demux_scan_if #(.CH(3), .W(2)) b3();

  mux_demux_scan #(.CH(4), .W(1), .DWELL(8)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_demux_scan #(.CH(3), .W(2), .DWELL(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    int          sel;
    int          held;
    logic [63:0] y;
    logic [63:0] yd;
    bit          wrap;
    bit          err;
  } mst_t;

  mst_t m4, m3;
  int   errors = 0;
  int   checks = 0;
  bit   armed  = 1'b0;
  int   wrap_ticks[$];

  // held counts cycles already spent on the current channel in scan mode.
  function automatic mst_t mstep(input mst_t s, input int ch, input int w, input int dwell,
                                 input logic r, input logic en, input logic mode, input logic ld,
                                 input int sin, input logic [63:0] i, input logic [63:0] d);
    mst_t        n;
    int          nsel;
    logic [63:0] mask;
    n    = s;
    mask = (64'd1 << w) - 64'd1;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (r) begin
      n.sel = 0; n.held = 0; n.y = '0; n.yd = '0;
      return n;
    end
    if (!en) return n;
    nsel = s.sel;
    if (ld && sin < ch) begin
      nsel   = sin;
      n.held = 0;
    end else begin
      n.err = ld;
      if (mode) begin
        n.held = s.held + 1;
        if (n.held == dwell) begin
          n.held = 0;
          nsel   = (s.sel + 1) % ch;
          n.wrap = (s.sel == ch - 1);
        end
      end else begin
        n.held = 0;
      end
    end
    n.y  = (i >> (nsel * w)) & mask;
    n.yd = (d & mask) << (nsel * w);
    if (BBM && nsel != s.sel) begin
      n.y  = '0;
      n.yd = '0;
    end
    n.sel = nsel;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = mstep(m4, 4, 1, 8, rst, b4.en, b4.mode, b4.sel_load, int'(b4.sel_in),
               64'(b4.I), 64'(b4.D));
    m3 = mstep(m3, 3, 2, 3, rst, b3.en, b3.mode, b3.sel_load, int'(b3.sel_in),
               64'(b3.I), 64'(b3.D));
    if (rst) armed = 1'b1;
    #1;
    if (armed) begin
      chk("y4",    64'(b4.Y),       m4.y);
      chk("yd4",   64'(b4.Yd),      m4.yd);
      chk("sel4",  64'(b4.sel_cur), 64'(m4.sel));
      chk("wrap4", 64'(b4.wrap),    64'(m4.wrap));
      chk("err4",  64'(b4.sel_err), 64'(m4.err));
      chk("y3",    64'(b3.Y),       m3.y);
      chk("yd3",   64'(b3.Yd),      m3.yd);
      chk("sel3",  64'(b3.sel_cur), 64'(m3.sel));
      chk("wrap3", 64'(b3.wrap),    64'(m3.wrap));
      chk("err3",  64'(b3.sel_err), 64'(m3.err));
    end
  endtask

  initial begin
    rst = 1'b1;
    b4.en = 1'b0; b4.mode = 1'b0; b4.sel_load = 1'b0; b4.sel_in = '0; b4.I = '0; b4.D = '0;
    b3.en = 1'b0; b3.mode = 1'b0; b3.sel_load = 1'b0; b3.sel_in = '0; b3.I = '0; b3.D = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_y",    64'(b4.Y),       64'd0);
    chk("rst_yd",   64'(b4.Yd),      64'd0);
    chk("rst_sel",  64'(b4.sel_cur), 64'd0);
    chk("rst_wrap", 64'(b4.wrap),    64'd0);
    chk("rst_err",  64'(b4.sel_err), 64'd0);

    b3.en = 1'b1; b3.mode = 1'b1; b3.I = 6'b10_01_11; b3.D = 2'b01;

    // Break-before-make sequence on a 0 -> 1 manual switch
    b4.en = 1'b1; b4.mode = 1'b0; b4.I = 4'b1111; b4.D = 1'b0;
    tick();
    chk("bbm_y0", 64'(b4.Y), 64'd1);
    b4.sel_load = 1'b1; b4.sel_in = 2'd1;
    tick();
    b4.sel_load = 1'b0;
    chk("bbm_y1",   64'(b4.Y),       BBM ? 64'd0 : 64'd1);
    chk("bbm_sel1", 64'(b4.sel_cur), 64'd1);
    tick();
    chk("bbm_y2", 64'(b4.Y), 64'd1);

    // Manual routing to channel 2
    b4.sel_load = 1'b1; b4.sel_in = 2'd2; b4.I = 4'b0100; b4.D = 1'b1;
    tick();
    b4.sel_load = 1'b0;
    chk("man_sel", 64'(b4.sel_cur), 64'd2);
    chk("man_y",   64'(b4.Y),       BBM ? 64'd0 : 64'd1);
    chk("man_yd",  64'(b4.Yd),      BBM ? 64'd0 : 64'b0100);
    repeat (20) tick();
    chk("man_hold_sel", 64'(b4.sel_cur), 64'd2);
    chk("man_hold_y",   64'(b4.Y),       64'd1);
    chk("man_hold_yd",  64'(b4.Yd),      64'b0100);

    // Scan from channel 0; wraps expected 32 and 64 cycles after the load
    b4.mode = 1'b1; b4.sel_load = 1'b1; b4.sel_in = 2'd0;
    tick();
    b4.sel_load = 1'b0;
    wrap_ticks.delete();
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (b4.wrap) wrap_ticks.push_back(t);
      if (t == 7) chk("scan_sel7", 64'(b4.sel_cur), 64'd0);
      if (t == 8) chk("scan_sel8", 64'(b4.sel_cur), 64'd1);
    end
    chk("wrap_count", 64'(wrap_ticks.size()), 64'd2);
    if (wrap_ticks.size() == 2) begin
      chk("wrap_first",  64'(wrap_ticks[0]), 64'd32);
      chk("wrap_second", 64'(wrap_ticks[1]), 64'd64);
    end

    // Load collides with terminal count on channel 3
    repeat (31) tick();
    chk("coll_pre_sel", 64'(b4.sel_cur), 64'd3);
    b4.sel_load = 1'b1; b4.sel_in = 2'd1;
    tick();
    b4.sel_load = 1'b0;
    chk("coll_sel",  64'(b4.sel_cur), 64'd1);
    chk("coll_wrap", 64'(b4.wrap),    64'd0);
    repeat (7) tick();
    chk("coll_hold", 64'(b4.sel_cur), 64'd1);
    tick();
    chk("coll_next", 64'(b4.sel_cur), 64'd2);

    // Freeze with en=0 in scan mode
    tick();
    chk("frz_pre_y", 64'(b4.Y), 64'd1);
    b4.en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      b4.I = 4'($urandom); b4.D = 1'($urandom);
      tick();
    end
    chk("frz_sel", 64'(b4.sel_cur), 64'd2);
    chk("frz_y",   64'(b4.Y),       64'd1);
    chk("frz_yd",  64'(b4.Yd),      64'b0100);
    b4.en = 1'b1;

    // Out-of-range load on the 3-channel instance
    b3.mode = 1'b0; b3.sel_load = 1'b1; b3.sel_in = 2'd1;
    tick();
    b3.sel_in = 2'd3;
    tick();
    chk("oor_err", 64'(b3.sel_err), 64'd1);
    chk("oor_sel", 64'(b3.sel_cur), 64'd1);
    b3.sel_load = 1'b0;
    tick();
    chk("oor_err_clear", 64'(b3.sel_err), 64'd0);

    // Randomized traffic on both instances
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      b4.en = ($urandom_range(0, 7) != 0);
      b3.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) b4.mode = ~b4.mode;
      if ($urandom_range(0, 31) == 0) b3.mode = ~b3.mode;
      b4.sel_load = ($urandom_range(0, 11) == 0);
      b3.sel_load = ($urandom_range(0, 7) == 0);
      b4.sel_in = 2'($urandom); b3.sel_in = 2'($urandom);
      b4.I = 4'($urandom); b4.D = 1'($urandom);
      b3.I = 6'($urandom); b3.D = 2'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_demux_scan.md
Name: mux_demux_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer and demultiplexer pair that share one channel selector. The selector is either loaded directly (manual mode) or advanced automatically by a dwell counter (scan mode). This block is the generalised, clocked successor to the fixed 2:1 mux and 1:4 demux. It is used for channel scanning and time-division routing of clock-domain-local signals.

Parameters:
CH, 4, number of channels (>=2)
W, 1, bits per channel
DWELL, 8, clock cycles spent on each channel in scan mode (>=1)
SELW, $clog2(CH), selector width (derived localparam, not overridable)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  global enable; 0 freezes all state
mode  input  1  0 = manual, 1 = scan
sel_load  input  1  single-cycle strobe to load sel_in
sel_in  input  SELW  channel requested on sel_load
I  input  CH*W  mux inputs; channel k at I[k*W +: W]
Y  output  W  registered mux output
D  input  W  demux input
Yd  output  CH*W  registered demux outputs; channel k at Yd[k*W +: W]
sel_cur  output  SELW  currently active channel
wrap  output  1  one-cycle pulse when scan advances from CH-1 to 0
sel_err  output  1  one-cycle pulse on an out-of-range sel_load

Behaviour:
- Reset (rst=1 at a clk edge): Y=0, Yd=0, sel_cur=0, dwell counter=0, wrap=0, sel_err=0. Reset overrides every other input.
- en=0: sel_cur, dwell counter, Y and Yd hold their values. wrap=0 and sel_err=0. sel_load is ignored and not queued.
- Datapath latency is 1 cycle:
  - Y <= I[sel_next] and Yd <= D placed in the sel_next slice, with all other slices 0.
  - sel_next is the selector value being registered in that same cycle, so a newly selected channel appears on Y/Yd in the same cycle sel_cur changes.
- sel_load with sel_in < CH (any mode): sel_next = sel_in and the dwell counter clears to 0.
- sel_load with sel_in >= CH: selector is unchanged and sel_err pulses for 1 cycle. This case only exists when CH is not a power of 2.
- Manual mode (mode=0): the selector changes only on sel_load and the dwell counter is held at 0.
- Scan mode (mode=1), no sel_load:
  - The dwell counter increments each enabled cycle.
  - When the counter equals DWELL-1, it returns to 0 and sel_next = (sel_cur+1) mod CH.
  - wrap pulses in the cycle sel_cur changes from CH-1 to 0.
- Simultaneous sel_load and dwell terminal count in scan mode: the load wins, the counter clears, and wrap does not pulse.
- Mode change 0->1: scanning starts from the current sel_cur with the counter at 0, so the first channel is held for DWELL cycles.
- Mode change 1->0: sel_cur freezes and the counter clears.
- DWELL=1: the selector advances every enabled cycle.
- Reset mid-scan: the next cycle behaves exactly as after power-on reset.
- No combinational path from any input to any output.

Optional Feature:
Macro BREAK_BEFORE_MAKE_EN.
- Defined: whenever sel_next differs from sel_cur, Y and Yd are forced to 0 for exactly one cycle. The new channel appears on the following cycle, and sel_cur updates in the blanking cycle.
- Defined, repeated changes: a further selector change during blanking restarts the blanking for one more cycle.
- Undefined: no blanking; switching behaves as described in Behaviour.

Test Plan:
- Reset: CH=4, W=1; hold rst=1 for 3 cycles, release -> Y=0, Yd=4'b0000, sel_cur=0, wrap=0, sel_err=0.
- Manual routing: mode=0; sel_load with sel_in=2; I=4'b0100, D=1 -> one cycle later sel_cur=2, Y=1, Yd=4'b0100. Hold 20 cycles -> sel_cur stays 2.
- Scan and wrap: mode=1, DWELL=8 -> sel_cur sequence 0,1,2,3,0, each held 8 cycles. wrap is high for exactly 1 cycle at each 3->0 transition, i.e. every 32 cycles.
- Load collision: mode=1; assert sel_load with sel_in=1 on the terminal-count cycle while sel_cur=3 -> sel_cur=1, wrap stays 0, next advance occurs 8 cycles later.
- Out-of-range and freeze: CH=3; sel_load with sel_in=3 -> sel_err pulses 1 cycle and sel_cur is unchanged. With en=0 for 10 cycles in scan mode -> sel_cur, Y and Yd are unchanged.
- BREAK_BEFORE_MAKE_EN defined: I=4'b1111, manual switch from 0 to 1 -> Y sequence is 1, 0, 1, with exactly one blanking cycle.
